// File: rtl/axis_frame_len_limit.sv
// AXI-Stream frame length limiter with a registered skid buffer: oversize frames are cut at MAX_BEATS
// with tlast forced and tuser[0] set. Statistics counters exist only when AXIS_FRAME_LEN_LIMIT_STATS_EN is defined.
module axis_frame_len_limit #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  stat_frames,
  output logic [CNT_WIDTH-1:0]  stat_bytes,
  output logic [15:0]           stat_trunc
);

  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int BCW    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

  state_t            state;
  logic [BCW-1:0]    beat_cnt;
  logic              ready_r;
  logic              out_valid;
  logic [BEAT_W-1:0] out_beat;
  logic              skid_valid;
  logic [BEAT_W-1:0] skid_beat;

  logic              in_hs;
  logic              wr_en;
  logic [BEAT_W-1:0] in_beat;
  logic              out_valid_n;
  logic [BEAT_W-1:0] out_beat_n;
  logic              skid_valid_n;
  logic [BEAT_W-1:0] skid_beat_n;

  assign in_hs         = s_axis_tvalid & ready_r;
  assign s_axis_tready = ready_r;
  assign m_axis_tvalid = out_valid;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = out_beat;

  // Beat as it will be stored: truncation point forces tlast and raises the flag in tuser[0].
  always_comb begin
    logic              last_mod;
    logic [USER_WIDTH-1:0] user_mod;
    last_mod    = s_axis_tlast;
    user_mod    = s_axis_tuser;
    user_mod[0] = 1'b0;
    if (!s_axis_tlast && beat_cnt == BCW'(MAX_BEATS - 1)) begin
      last_mod    = 1'b1;
      user_mod[0] = 1'b1;
    end
    wr_en   = in_hs && (state == PASS);
    in_beat = {s_axis_tdata, s_axis_tkeep, last_mod, s_axis_tid, s_axis_tdest, user_mod};
  end

  always_comb begin
    out_valid_n  = out_valid;
    out_beat_n   = out_beat;
    skid_valid_n = skid_valid;
    skid_beat_n  = skid_beat;
    if (!out_valid || m_axis_tready) begin
      // Output slot frees up: the skid beat is older than any incoming one.
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_beat_n   = skid_beat;
        skid_valid_n = 1'b0;
      end else begin
        out_valid_n = wr_en;
        if (wr_en) out_beat_n = in_beat;
      end
    end else if (wr_en) begin
      skid_valid_n = 1'b1;
      skid_beat_n  = in_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_r    <= 1'b0;
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else begin
      ready_r    <= !skid_valid_n;
      out_valid  <= out_valid_n;
      out_beat   <= out_beat_n;
      skid_valid <= skid_valid_n;
      skid_beat  <= skid_beat_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PASS;
      beat_cnt <= '0;
    end else if (in_hs) begin
      case (state)
        PASS: begin
          if (s_axis_tlast) begin
            beat_cnt <= '0;
          end else if (beat_cnt == BCW'(MAX_BEATS - 1)) begin
            state <= DROP;
          end else begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            beat_cnt <= '0;
            state    <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
  logic out_hs;
  assign out_hs = out_valid & m_axis_tready;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n = n + CNT_WIDTH'(k[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_bytes  <= '0;
      stat_trunc  <= '0;
    end else if (out_hs) begin
      stat_bytes <= stat_bytes + popcount(m_axis_tkeep);
      if (m_axis_tlast) begin
        stat_frames <= stat_frames + CNT_WIDTH'(1);
        if (m_axis_tuser[0]) stat_trunc <= sat_inc(stat_trunc);
      end
    end
  end
`else
  assign stat_frames = '0;
  assign stat_bytes  = '0;
  assign stat_trunc  = '0;
`endif

endmodule

// File: tb/tb_axis_frame_len_limit.sv
// Bench for axis_frame_len_limit (MAX_BEATS=4): directed and random frames against a frame-position reference model.
module tb_axis_frame_len_limit;

  localparam int DW = 64, KW = 8, IW = 8, DSW = 8, UW = 2, MB = 4, CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [IW-1:0] s_tid = '0;
  logic [DSW-1:0] s_tdest = '0;
  logic [UW-1:0] s_tuser = '0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [IW-1:0] m_tid;
  logic [DSW-1:0] m_tdest;
  logic [UW-1:0] m_tuser;
  logic [CW-1:0] stat_frames, stat_bytes;
  logic [15:0]   stat_trunc;

  axis_frame_len_limit #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
    .USER_WIDTH(UW), .MAX_BEATS(MB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .stat_frames(stat_frames), .stat_bytes(stat_bytes), .stat_trunc(stat_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    frame_pos = 0;
  int    mdl_frames = 0, mdl_bytes = 0, mdl_trunc = 0;
  int    ready_mode = 0;
  int    rcyc = 0;
  bit    prev_stall = 0;
  logic [127:0] prev_out = '0;

  function automatic logic [127:0] cur_out();
    return 128'({m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser});
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: what happens to a beat depends only on its position within the input frame.
  task automatic model_input();
    beat_t b;
    int pos;
    pos = frame_pos;
    frame_pos = s_tlast ? 0 : frame_pos + 1;
    b.data = s_tdata; b.keep = s_tkeep; b.last = s_tlast;
    b.id = s_tid; b.dest = s_tdest; b.user = s_tuser; b.user[0] = 1'b0;
    if (pos < MB - 1 || (pos == MB - 1 && s_tlast)) begin
      exp_q.push_back(b);
    end else if (pos == MB - 1) begin
      b.last = 1'b1; b.user[0] = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic step(output bit in_hs);
    bit out_hs;
    beat_t e;
    @(negedge clk);
    chk("s_tready_vs_occupancy", 128'(s_tready), 128'(exp_q.size() < 2));
    chk("m_tvalid_vs_occupancy", 128'(m_tvalid), 128'(exp_q.size() > 0));
    if (prev_stall) chk("stall_hold", cur_out(), prev_out);
    in_hs  = s_tvalid && s_tready;
    out_hs = m_tvalid && m_tready;
    if (out_hs) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 128'(m_tvalid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("tdata", 128'(m_tdata), 128'(e.data));
        chk("tkeep", 128'(m_tkeep), 128'(e.keep));
        chk("tlast", 128'(m_tlast), 128'(e.last));
        chk("tid",   128'(m_tid),   128'(e.id));
        chk("tdest", 128'(m_tdest), 128'(e.dest));
        chk("tuser", 128'(m_tuser), 128'(e.user));
        mdl_bytes += $countones(e.keep);
        if (e.last) begin
          mdl_frames++;
          if (e.user[0] && mdl_trunc < 65535) mdl_trunc++;
        end
      end
    end
    if (in_hs) model_input();
    prev_stall = m_tvalid && !m_tready;
    prev_out   = cur_out();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_tready = 1'b1;
      1: m_tready = 1'($urandom_range(0, 1));
      default: m_tready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
    endcase
    rcyc++;
  endtask

  task automatic send_frame(input int len, input logic [KW-1:0] last_keep, input int gap_pct, input int nsend);
    bit h;
    int n;
    for (int b = 0; b < nsend; b++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_tvalid = 1'b0;
        step(h);
      end
      s_tdata  = {$urandom, $urandom};
      s_tkeep  = (b == len - 1) ? last_keep : 8'hFF;
      s_tlast  = (b == len - 1);
      s_tid    = 8'($urandom);
      s_tdest  = 8'($urandom);
      s_tuser  = 2'($urandom);
      s_tvalid = 1'b1;
      n = 0;
      h = 0;
      while (!h && n < 200) begin
        step(h);
        n++;
      end
      if (!h) begin
        chk("send_timeout", 128'(h), 128'(1));
        return;
      end
    end
  endtask

  task automatic drain();
    bit h;
    int n;
    s_tvalid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      step(h);
      n++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    repeat (2) step(h);
    ready_mode = 0;
    m_tready = 1'b1;
  endtask

  task automatic check_stats(input string tag);
`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
    chk({tag, "_frames"}, 128'(stat_frames), 128'(32'(mdl_frames)));
    chk({tag, "_bytes"},  128'(stat_bytes),  128'(32'(mdl_bytes)));
    chk({tag, "_trunc"},  128'(stat_trunc),  128'(16'(mdl_trunc)));
`else
    chk({tag, "_frames"}, 128'(stat_frames), 128'(0));
    chk({tag, "_bytes"},  128'(stat_bytes),  128'(0));
    chk({tag, "_trunc"},  128'(stat_trunc),  128'(0));
`endif
  endtask

  task automatic do_reset(input int cycles);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    exp_q.delete();
    frame_pos = 0;
    mdl_frames = 0; mdl_bytes = 0; mdl_trunc = 0;
    prev_stall = 0;
    @(negedge clk);
    chk("rst_s_tready", 128'(s_tready), 128'(0));
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_m_tdata",  128'(m_tdata),  128'(0));
    chk("rst_m_tlast",  128'(m_tlast),  128'(0));
    chk("rst_stat_frames", 128'(stat_frames), 128'(0));
    chk("rst_stat_bytes",  128'(stat_bytes),  128'(0));
    chk("rst_stat_trunc",  128'(stat_trunc),  128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    ready_mode = 0;
    m_tready = 1'b1;
    do_reset(3);

    // 4-beat frame: exactly MAX_BEATS with tlast, 28 bytes, no truncation.
    send_frame(4, 8'h0F, 0, 4);
    drain();
    check_stats("plain4");
`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
    chk("plain4_bytes_28", 128'(stat_bytes), 128'(28));
`endif

    // Oversize 7-beat frame truncated, then a 2-beat frame intact.
    send_frame(7, 8'hFF, 0, 7);
    send_frame(2, 8'h3C, 0, 2);
    drain();
    check_stats("trunc7");

    // Single-beat frames and another exact-length frame.
    send_frame(1, 8'h01, 0, 1);
    send_frame(4, 8'h80, 0, 4);
    send_frame(1, 8'hF0, 0, 1);
    drain();
    check_stats("single");

    // Continuous input while m_tready follows 1,0,0,1.
    ready_mode = 2;
    rcyc = 0;
    send_frame(3, 8'hFF, 0, 3);
    send_frame(5, 8'h07, 0, 5);
    send_frame(2, 8'h0F, 0, 2);
    send_frame(6, 8'h03, 0, 6);
    drain();
    check_stats("stall");

    // Random lengths, gaps and backpressure.
    ready_mode = 1;
    for (int f = 0; f < 25; f++) begin
      int len;
      logic [KW-1:0] lk;
      len = $urandom_range(1, 9);
      lk = 8'($urandom_range(1, 255));
      send_frame(len, lk, 30, len);
    end
    drain();
    check_stats("random");

    // Reset in the middle of an oversize frame while discarding beats.
    send_frame(7, 8'hFF, 0, 6);
    do_reset(1);
    send_frame(2, 8'hAA, 0, 2);
    send_frame(4, 8'h11, 0, 4);
    drain();
    check_stats("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_frame_len_limit.md
Name: axis_frame_len_limit

Overview:
- Single-clock AXI-Stream stage placed directly downstream of the clock-crossing AXI-Stream FIFO on the read (m_clk) side.
- Forwards frames through a registered skid buffer.
- Enforces a maximum frame length in beats: oversize frames are truncated with tlast forced and a flag bit set in tuser, and the remaining beats are discarded.
- Optionally keeps frame, byte and truncation statistics.

Parameters:
- DATA_WIDTH, 64, tdata width in bits
- KEEP_WIDTH, DATA_WIDTH/8 (rounded up), tkeep width
- ID_WIDTH, 8, tid width
- DEST_WIDTH, 8, tdest width
- USER_WIDTH, 1, tuser width (>=1); bit 0 is the truncation flag on output
- MAX_BEATS, 256, maximum beats per frame (>=2)
- CNT_WIDTH, 32, width of the frame and byte counters

Ports:
- clk  in  1  stage clock
- rst_n  in  1  synchronous active-low reset
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in/in/in/out/in/in/in/in  DATA/KEEP/1/1/1/ID/DEST/USER  input stream from FIFO
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out/out/out/in/out/out/out/out  same widths  output stream
- stat_frames  out  CNT_WIDTH  frames completed on output
- stat_bytes  out  CNT_WIDTH  bytes (tkeep ones) accepted on output
- stat_trunc  out  16  frames truncated

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - m_axis_tvalid=0; s_axis_tready=0 during reset, 1 on the first cycle after.
  - m_axis data fields 0; skid buffer empty; beat_cnt=0; state=PASS; all stat outputs 0.
  - Reset mid-frame discards buffered beats without emitting tlast.
- Skid buffer:
  - Output register plus one skid register.
  - s_axis_tready is registered and equals !skid_valid.
  - Latency: 1 cycle from input handshake to m_axis_tvalid.
  - Full throughput (1 beat/cycle) when m_axis_tready=1.
  - When m_axis_tready drops, at most one extra beat lands in the skid register.
  - Output fields are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Beat counter: beat_cnt, clog2(MAX_BEATS) bits, counts accepted input beats of the current frame. Reset to 0 after a tlast beat is accepted.
- FSM, evaluated on each accepted input beat:
  - PASS:
    - Beat forwarded unchanged except tuser[0]=0.
    - If tlast=1: beat_cnt<=0, stay in PASS.
    - Else if beat_cnt==MAX_BEATS-1: forward with tlast=1 and tuser[0]=1, go to DROP.
    - Else beat_cnt++.
  - DROP:
    - s_axis_tready follows the normal skid rule; accepted beats are not written to the buffer.
    - On tlast=1: beat_cnt<=0, go to PASS.
  - A frame of exactly MAX_BEATS beats with tlast on the last beat is not truncated.
- Single-beat frames (tlast on the first beat) are legal and pass in PASS.
- tvalid/tready simultaneity: input and output handshakes in the same cycle are allowed in both states.
- Stats update on the output handshake:
  - stat_bytes += popcount(tkeep).
  - stat_frames++ when tlast=1.
  - stat_trunc++ when tlast=1 and tuser[0]=1.
  - stat_frames and stat_bytes wrap modulo 2^CNT_WIDTH; stat_trunc saturates at 0xFFFF.

Optional Feature:
- Macro: AXIS_FRAME_LEN_LIMIT_STATS_EN
- Defined: stat_frames, stat_bytes and stat_trunc are implemented as above.
- Undefined: no counter logic; stat outputs are tied to 0. The data path is unchanged.

Test Plan:
- Reset, then a 4-beat frame (tkeep=0xFF, last beat tkeep=0x0F) with m_axis_tready=1 -> 4 beats out with 1-cycle latency, tlast on beat 4, tuser[0]=0; stat_frames=1, stat_bytes=28, stat_trunc=0.
- MAX_BEATS=4, 7-beat frame -> 4 beats out, beat 4 has tlast=1 and tuser[0]=1; beats 5-7 consumed and not emitted; next frame of 2 beats passes intact; stat_trunc=1, stat_frames=2.
- MAX_BEATS=4, exactly 4-beat frame ending in tlast -> no truncation, tuser[0]=0, stat_trunc=0.
- Continuous input with m_axis_tready toggling 1,0,0,1 -> no beat lost or duplicated; s_axis_tready low only while the skid register is full; output stable while stalled.
- rst_n asserted for 1 cycle mid-frame in DROP -> next cycle m_axis_tvalid=0 and all stats 0; the following frame starts in PASS with beat_cnt=0.
- Feature undefined, 3 frames sent -> stat outputs remain 0 and the data path matches the defined-macro case.
